// File: rtl/trisc_pkg.sv
// Shared encodings for the TRISC memory arbiter: FSM states, owner codes,
// default bus widths and the tie-break helper.
package trisc_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LD  = 1'b1;

    // Single requester wins outright; on a tie the one that did not own the
    // memory last time goes first.
    function automatic logic pick_owner(input logic cpu_req, input logic ld_req,
                                        input logic last_owner);
        if (cpu_req && ld_req)
            return (last_owner == OWN_CPU) ? OWN_LD : OWN_CPU;
        else if (ld_req)
            return OWN_LD;
        else
            return OWN_CPU;
    endfunction

endpackage

// File: rtl/trisc_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory array.
interface trisc_mem_arbiter_if
    import trisc_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_done;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_done;

    logic [DW-1:0] rdata;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_done, ld_gnt, ld_done,
        output rdata, mem_ce, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_done, ld_gnt, ld_done,
        input  rdata, mem_ce, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/trisc_access_timer.sv
// Loadable down-counter that measures the fixed memory access length.
module trisc_access_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, regardless of block evaluation order.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - W'(1);
    end

    assign zero = (count == '0);
endmodule

// File: rtl/trisc_mem_arbiter.sv
// Two-requester arbiter for the TRISC program/data memory: CPU controller vs
// loader, fixed-length access, 4-phase req/done handshake, falling-edge state.
module trisc_mem_arbiter
    import trisc_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int MEM_CYCLES = 2
) (
    input  logic                SysClock,
    input  logic                StartStop,
    trisc_mem_arbiter_if.slave  bus
);
    localparam int            TW         = $clog2(MEM_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(MEM_CYCLES - 1);

    logic [1:0]    state;
    logic          owner;
    logic          last_owner;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

    logic any_req;
    logic grant_owner;
    logic owner_req;
    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    assign any_req     = bus.cpu_req | bus.ld_req;
    assign grant_owner = pick_owner(bus.cpu_req, bus.ld_req, last_owner);
    assign owner_req   = (owner == OWN_CPU) ? bus.cpu_req : bus.ld_req;
    assign timer_load  = (state == ST_IDLE) && any_req;
    assign timer_dec   = (state == ST_ACCESS);

    trisc_access_timer #(.W(TW)) u_timer (
        .clk      (SysClock),
        .rst_n    (StartStop),
        .load     (timer_load),
        .load_val (TIMER_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // last_owner resets to LD so the CPU wins the first tie after reset.
    always_ff @(negedge SysClock or negedge StartStop) begin
        if (!StartStop) begin
            state      <= ST_IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_LD;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner   <= grant_owner;
                        we_q    <= (grant_owner == OWN_LD) ? bus.ld_we    : bus.cpu_we;
                        addr_q  <= (grant_owner == OWN_LD) ? bus.ld_addr  : bus.cpu_addr;
                        wdata_q <= (grant_owner == OWN_LD) ? bus.ld_wdata : bus.cpu_wdata;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (timer_zero) begin
                        if (!we_q)
                            rdata_q <= bus.mem_rdata;
                        last_owner <= owner;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!owner_req)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so reset kills them immediately.
    assign bus.mem_ce    = (state == ST_ACCESS);
    assign bus.mem_we    = (state == ST_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state != ST_IDLE);

    assign bus.cpu_gnt  = (state != ST_IDLE) && (owner == OWN_CPU);
    assign bus.ld_gnt   = (state != ST_IDLE) && (owner == OWN_LD);
    assign bus.cpu_done = (state == ST_DONE) && (owner == OWN_CPU);
    assign bus.ld_done  = (state == ST_DONE) && (owner == OWN_LD);
endmodule

// File: tb/tb_trisc_mem_arbiter.sv
// Directed bench for trisc_mem_arbiter: array model on the memory side and a
// read-data scoreboard; a second instance covers the single-cycle access build.
module tb_trisc_mem_arbiter;

    logic SysClock  = 1'b0;
    logic StartStop = 1'b0;
    always #5 SysClock = ~SysClock;

    trisc_mem_arbiter_if #(.AW(4), .DW(8)) bus  ();
    trisc_mem_arbiter_if #(.AW(4), .DW(8)) bus1 ();

    trisc_mem_arbiter #(.AW(4), .DW(8), .MEM_CYCLES(2)) dut (
        .SysClock  (SysClock),
        .StartStop (StartStop),
        .bus       (bus)
    );

    trisc_mem_arbiter #(.AW(4), .DW(8), .MEM_CYCLES(1)) dut1 (
        .SysClock  (SysClock),
        .StartStop (StartStop),
        .bus       (bus1)
    );

    // Memory array driven by the arbiter, and the bench's expected contents.
    logic [7:0] mem   [16] = '{8'h10, 8'h11, 8'h12, 8'hA5, 8'h14, 8'h15, 8'h16, 8'h17,
                               8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};
    logic [7:0] model [16] = '{8'h10, 8'h11, 8'h12, 8'hA5, 8'h14, 8'h15, 8'h16, 8'h17,
                               8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};

    always @(negedge SysClock)
        if (bus.mem_ce && bus.mem_we)
            mem[bus.mem_addr] = bus.mem_wdata;

    assign bus.mem_rdata  = mem[bus.mem_addr];
    assign bus1.mem_rdata = 8'h3C;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb [$];
    logic [7:0] last_read;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [3:0] a,
                             input logic [7:0] d);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic drive_ld(input logic req, input logic we, input logic [3:0] a,
                            input logic [7:0] d);
        bus.ld_req = req; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
    endtask

    // Steps posedges until the selected done rises (sel 0=cpu, 1=ld, 2=cpu of dut1).
    task automatic wait_done(input int sel, input int max_cyc, output int cyc,
                             output int ce_cnt, output int we_cnt,
                             output logic [3:0] first_addr, output logic addr_stable);
        logic       done_now;
        logic       ce;
        logic       we_s;
        logic [3:0] a;
        cyc = 0; ce_cnt = 0; we_cnt = 0; first_addr = '0; addr_stable = 1'b1;
        done_now = 1'b0;
        while (!done_now && cyc < max_cyc) begin
            @(posedge SysClock);
            cyc++;
            if (sel == 2) begin
                ce = bus1.mem_ce; we_s = bus1.mem_we; a = bus1.mem_addr;
                done_now = bus1.cpu_done;
            end else begin
                ce = bus.mem_ce; we_s = bus.mem_we; a = bus.mem_addr;
                done_now = (sel == 1) ? bus.ld_done : bus.cpu_done;
                check("gnt_exclusive", {31'd0, bus.cpu_gnt & bus.ld_gnt}, 0);
            end
            if (ce) begin
                if (ce_cnt == 0) first_addr = a;
                else if (a != first_addr) addr_stable = 1'b0;
                ce_cnt++;
            end
            if (we_s) we_cnt++;
        end
        check("done_seen", {31'd0, done_now}, 1);
    endtask

    task automatic sb_check(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            exp = sb.pop_front();
            last_read = exp;
            check(tag, {24'd0, obs}, {24'd0, exp});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         cyc, ce_cnt, we_cnt, hold_ce;
        logic [3:0] fa;
        logic       stable;

        drive_cpu(0, 0, 4'h0, 8'h00);
        drive_ld(0, 0, 4'h0, 8'h00);
        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 4'h0; bus1.cpu_wdata = 8'h00;
        bus1.ld_req  = 0; bus1.ld_we  = 0; bus1.ld_addr  = 4'h0; bus1.ld_wdata  = 8'h00;
        last_read = 8'h00;

        // Reset state
        repeat (3) @(posedge SysClock);
        check("rst_busy",    {31'd0, bus.busy},    0);
        check("rst_mem_ce",  {31'd0, bus.mem_ce},  0);
        check("rst_mem_we",  {31'd0, bus.mem_we},  0);
        check("rst_gnt",     {30'd0, bus.cpu_gnt, bus.ld_gnt}, 0);
        check("rst_done",    {30'd0, bus.cpu_done, bus.ld_done}, 0);
        check("rst_rdata",   {24'd0, bus.rdata},   0);
        check("rst_addr",    {28'd0, bus.mem_addr}, 0);
        StartStop = 1'b1;

        // Reset during the first ACCESS cycle of a CPU write
        @(posedge SysClock);
        drive_cpu(1, 1, 4'h9, 8'hEE);
        @(posedge SysClock);
        check("mid_ce_before",  {31'd0, bus.mem_ce}, 1);
        check("mid_we_before",  {31'd0, bus.mem_we}, 1);
        #2 StartStop = 1'b0;
        #1;
        check("mid_ce_after",   {31'd0, bus.mem_ce}, 0);
        check("mid_we_after",   {31'd0, bus.mem_we}, 0);
        check("mid_busy_after", {31'd0, bus.busy},   0);
        check("mid_gnt_after",  {31'd0, bus.cpu_gnt}, 0);
        drive_cpu(0, 0, 4'h0, 8'h00);
        @(posedge SysClock);
        check("mid_mem_unchanged", {24'd0, mem[9]}, {24'd0, model[9]});
        check("mid_we_in_reset",   {31'd0, bus.mem_we}, 0);
        StartStop = 1'b1;

        // CPU read of address 3, req held 5 cycles after done
        @(posedge SysClock);
        drive_cpu(1, 0, 4'h3, 8'h00);
        sb.push_back(model[3]);
        wait_done(0, 10, cyc, ce_cnt, we_cnt, fa, stable);
        check("rd_latency", cyc, 3);
        check("rd_ce_cycles", ce_cnt, 2);
        check("rd_we_cycles", we_cnt, 0);
        check("rd_addr", {28'd0, fa}, 4'h3);
        sb_check("rd_rdata", bus.rdata);
        hold_ce = 0;
        repeat (5) begin
            @(posedge SysClock);
            if (bus.mem_ce) hold_ce++;
        end
        check("rd_hold_done", {31'd0, bus.cpu_done}, 1);
        check("rd_hold_no_reaccess", hold_ce, 0);
        drive_cpu(0, 0, 4'h0, 8'h00);
        @(posedge SysClock);
        check("rd_release_busy", {31'd0, bus.busy}, 0);
        check("rd_release_done", {31'd0, bus.cpu_done}, 0);

        // Loader write of 5A to F, then CPU readback
        drive_ld(1, 1, 4'hF, 8'h5A);
        model[15] = 8'h5A;
        wait_done(1, 10, cyc, ce_cnt, we_cnt, fa, stable);
        check("ldwr_latency", cyc, 3);
        check("ldwr_we_cycles", we_cnt, 2);
        check("ldwr_addr", {28'd0, fa}, 4'hF);
        check("ldwr_cpu_gnt", {31'd0, bus.cpu_gnt}, 0);
        check("ldwr_rdata_held", {24'd0, bus.rdata}, {24'd0, last_read});
        drive_ld(0, 0, 4'h0, 8'h00);
        @(posedge SysClock);
        check("ldwr_mem", {24'd0, mem[15]}, {24'd0, model[15]});
        drive_cpu(1, 0, 4'hF, 8'h00);
        sb.push_back(model[15]);
        wait_done(0, 10, cyc, ce_cnt, we_cnt, fa, stable);
        sb_check("readback_rdata", bus.rdata);
        drive_cpu(0, 0, 4'h0, 8'h00);
        @(posedge SysClock);

        // Round robin from reset: CPU, then loader, then CPU again
        StartStop = 1'b0;
        @(posedge SysClock);
        StartStop = 1'b1;
        for (int r = 0; r < 2; r++) begin
            logic [3:0] ca;
            logic [3:0] la;
            ca = (r == 0) ? 4'h1 : 4'h6;
            la = (r == 0) ? 4'h2 : 4'h8;
            @(posedge SysClock);
            drive_cpu(1, 0, ca, 8'h00);
            drive_ld(1, 0, la, 8'h00);
            sb.push_back(model[ca]);
            sb.push_back(model[la]);
            @(posedge SysClock);
            check("rr_cpu_first", {31'd0, bus.cpu_gnt}, 1);
            check("rr_ld_waits", {31'd0, bus.ld_gnt}, 0);
            wait_done(0, 10, cyc, ce_cnt, we_cnt, fa, stable);
            sb_check("rr_cpu_rdata", bus.rdata);
            drive_cpu(0, 0, 4'h0, 8'h00);
            wait_done(1, 12, cyc, ce_cnt, we_cnt, fa, stable);
            check("rr_ld_addr", {28'd0, fa}, {28'd0, la});
            sb_check("rr_ld_rdata", bus.rdata);
            drive_ld(0, 0, 4'h0, 8'h00);
            @(posedge SysClock);
            check("rr_idle", {31'd0, bus.busy}, 0);
        end

        // rdata survives a write and IDLE
        drive_ld(1, 1, 4'h5, 8'h77);
        model[5] = 8'h77;
        wait_done(1, 10, cyc, ce_cnt, we_cnt, fa, stable);
        drive_ld(0, 0, 4'h0, 8'h00);
        repeat (2) @(posedge SysClock);
        check("hold_rdata_idle", {24'd0, bus.rdata}, {24'd0, last_read});
        check("hold_mem5", {24'd0, mem[5]}, {24'd0, model[5]});

        // Loader request arriving mid CPU access
        drive_cpu(1, 0, 4'h4, 8'h00);
        sb.push_back(model[4]);
        @(posedge SysClock);
        check("cont_cpu_addr", {28'd0, bus.mem_addr}, 4'h4);
        drive_ld(1, 1, 4'h7, 8'h99);
        model[7] = 8'h99;
        bus.cpu_addr = 4'h0;
        wait_done(0, 10, cyc, ce_cnt, we_cnt, fa, stable);
        check("cont_addr_stable", {31'd0, stable}, 1);
        check("cont_addr_latched", {28'd0, fa}, 4'h4);
        check("cont_ld_no_gnt", {31'd0, bus.ld_gnt}, 0);
        sb_check("cont_cpu_rdata", bus.rdata);
        @(posedge SysClock);
        check("cont_ld_waits_done", {30'd0, bus.ld_gnt, bus.ld_done}, 0);
        check("cont_addr_in_done", {28'd0, bus.mem_addr}, 4'h4);
        drive_cpu(0, 0, 4'h0, 8'h00);
        wait_done(1, 12, cyc, ce_cnt, we_cnt, fa, stable);
        check("cont_ld_addr", {28'd0, fa}, 4'h7);
        check("cont_ld_we_cycles", we_cnt, 2);
        drive_ld(0, 0, 4'h0, 8'h00);
        @(posedge SysClock);
        check("cont_ld_mem", {24'd0, mem[7]}, {24'd0, model[7]});

        // Single-cycle access build with held request
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 4'h0;
        sb.push_back(8'h3C);
        wait_done(2, 10, cyc, ce_cnt, we_cnt, fa, stable);
        check("mc1_latency", cyc, 2);
        check("mc1_ce_cycles", ce_cnt, 1);
        sb_check("mc1_rdata", bus1.rdata);
        hold_ce = 0;
        repeat (5) begin
            @(posedge SysClock);
            if (bus1.mem_ce) hold_ce++;
        end
        check("mc1_no_reaccess", hold_ce, 0);
        check("mc1_hold_done", {31'd0, bus1.cpu_done}, 1);
        bus1.cpu_req = 0;
        @(posedge SysClock);
        check("mc1_release_busy", {31'd0, bus1.busy}, 0);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
